strip_result_readout: RTL and testbench
=======================================

Name: strip_result_readout

Overview:
- Drains one convolution strip's 23-bit result BRAM after the conv unit asserts done.
- Sequences read addresses and absorbs BRAM read latency.
- Requantises each signed accumulator to 8 bits (round, shift, clamp).
- Streams pixels out over a valid/ready handshake to the frame-assembly/writeback stage. One instance per horizontal strip, directly downstream of each conv unit.

Parameters:
- OUT_COUNT, 6216, number of results in the strip ((224-3+1)*(30-3+1) = 222*28).
- ADDR_W, 13, strip result BRAM address width.
- IN_W, 23, accumulator width.
- OUT_W, 8, output pixel width.
- SHIFT, 4, requantisation right-shift amount (0..15).
- RD_LAT, 1, BRAM address-to-data latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- strip_done  in  1  conv unit done level; a rising edge starts a drain
- strip_addr  out  ADDR_W  read address to conv unit's result-address input
- strip_data  in  IN_W  signed result from strip result BRAM
- pix_data  out  OUT_W  requantised pixel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  downstream ready
- pix_last  out  1  marks the final pixel of the strip
- busy  out  1  drain in progress
- frame_done  out  1  one-cycle pulse when the last pixel is accepted

Behaviour:
- Clocking and reset: one clock (clk). reset is asynchronous, active-high.
- Reset values: strip_addr=0, pix_data=0, pix_valid=0, pix_last=0, busy=0, frame_done=0. FSM goes to IDLE, counters clear, FIFO empties.
- Start: strip_done is registered and edge-detected. A rise while in IDLE starts a drain.
  - If strip_done is already high when reset releases, no start until it falls and rises again.
  - Rises while busy are ignored.
- FSM states:
  - IDLE: wait for start edge, then go to ISSUE.
  - ISSUE: present strip_addr = rd_cnt each cycle a read is issued.
    - Issue only when fifo_count + inflight < RD_LAT+1 (credit rule). This guarantees no data loss under backpressure.
    - rd_cnt increments per issued read.
    - Go to DRAIN after issuing address OUT_COUNT-1.
  - DRAIN: no new reads. Wait until all in-flight data has landed and the last pixel is accepted, then go to DONE.
  - DONE: pulse frame_done for one cycle, then go to IDLE.
- Read pipeline:
  - A shift register of depth RD_LAT tags issued reads.
  - When a tag emerges, strip_data is requantised and pushed into a FIFO of depth RD_LAT+1.
- Requantisation (combinational at FIFO input):
  - t = strip_data + (SHIFT>0 ? 1<<(SHIFT-1) : 0), sign-extended to IN_W+1.
  - r = t >>> SHIFT (arithmetic).
  - r is then clamped per the Optional Feature.
- Output handshake:
  - pix_valid = FIFO not empty; pix_data and pix_last come from the FIFO head.
  - A transfer happens when pix_valid && pix_ready.
  - While pix_valid=1 && pix_ready=0, pix_data and pix_last hold stable.
  - pix_last=1 only on the entry whose address was OUT_COUNT-1.
- Throughput and latency:
  - With pix_ready held high: one pixel per cycle.
  - First pix_valid appears RD_LAT+1 cycles after the start edge is detected.
- Simultaneous FIFO push and pop in one cycle are both honoured; occupancy is unchanged.
- Address wrap: strip_addr never exceeds OUT_COUNT-1. It returns to 0 in IDLE.
- busy=1 from the start edge through the DONE cycle inclusive.
- Reset mid-drain: immediate abort with all outputs at reset values. No partial frame_done is emitted.

Optional Feature:
- Macro: STRIP_READOUT_RELU_EN.
- Defined: ReLU plus unsigned saturation. r<0 maps to 0; r>255 maps to 255. pix_data is unsigned 0..255.
- Undefined: signed saturation. r is clamped to -128..127 and pix_data is two's complement.

Decomposition:
- Shared package (conv_pkg): IN_W, OUT_W, frame dimensions (224, 30, kernel 3), derived OUT_COUNT, and the FSM state encoding (IDLE, ISSUE, DRAIN, DONE as 2-bit localparams).
- One natural sub-module: readout_fifo. It is a small synchronous FIFO with depth RD_LAT+1, width OUT_W+1 (data plus last flag), push/pop/count, and asynchronous reset.
- The requantiser stays inline.

Test Plan:
- Free-flow: OUT_COUNT=8, SHIFT=4, BRAM preloaded with addr*16+8, ready=1. Expect pixels 1..8 on consecutive cycles, pix_last on the 8th, frame_done one cycle after the 8th accept.
- Rounding and clamp: values 23'sd7, 23'sd8, 23'sd5000, -23'sd40 with SHIFT=4.
  - With RELU_EN: expect 0, 1, 255, 0.
  - Without RELU_EN: expect 0, 1, 127, -2.
- Backpressure: toggle pix_ready 1-0-0-1 randomly, RD_LAT=2. Expect no pixel dropped or duplicated, pix_data stable while stalled, and strip_addr never more than 3 reads ahead of accepted beats.
- Start edge: hold strip_done high across and after completion. Expect exactly one drain. Lower then raise it: expect a second drain starting at address 0.
- Reset mid-drain: assert reset after 3 of 8 pixels are accepted. Expect pix_valid=0, busy=0, strip_addr=0 asynchronously, and no frame_done. A new strip_done rise re-drains from address 0.
- Ignored re-trigger: pulse strip_done while busy. Expect no effect on address sequence or pixel count.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the strip convolution datapath.
// Frame geometry sets the default number of results held in one strip BRAM.
package conv_pkg;

  localparam int FRAME_W  = 224;
  localparam int STRIP_H  = 30;
  localparam int KERNEL_K = 3;

  localparam int OUT_COLS = FRAME_W - KERNEL_K + 1;
  localparam int OUT_ROWS = STRIP_H - KERNEL_K + 1;

  localparam int DEF_OUT_COUNT = OUT_COLS * OUT_ROWS;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_IN_W      = 23;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_SHIFT     = 4;
  localparam int DEF_RD_LAT    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } readout_state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO holding requantised pixels plus their last flag.
// The head entry is presented combinationally so a stalled beat stays stable.
module readout_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic [occ_w(DEPTH)-1:0]   count,
  output logic                      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = occ_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/strip_result_readout.sv
// Drains a strip result BRAM after conv done, requantises to OUT_W and streams pixels out.
// Define STRIP_READOUT_RELU_EN for ReLU + unsigned saturation; default is signed saturation.
module strip_result_readout
  import conv_pkg::*;
#(
  parameter int OUT_COUNT = DEF_OUT_COUNT,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strip_done,
  output logic [ADDR_W-1:0] strip_addr,
  input  logic [IN_W-1:0]   strip_data,
  output logic [OUT_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int CNT_W      = occ_w(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_COUNT - 1);

  localparam int ROUND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
`ifdef STRIP_READOUT_RELU_EN
  localparam int SAT_MAX_INT = (1 << OUT_W) - 1;
  localparam int SAT_MIN_INT = 0;
`else
  localparam int SAT_MAX_INT = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_INT = -(1 << (OUT_W - 1));
`endif
  localparam logic signed [IN_W:0] ROUND  = (IN_W + 1)'(ROUND_INT);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'(SAT_MAX_INT);
  localparam logic signed [IN_W:0] SAT_LO = (IN_W + 1)'(SAT_MIN_INT);

  readout_state_t state_reg;
  readout_state_t state_next;

  logic              done_q_reg;
  logic              done_q2_reg;
  logic              start_rise;
  logic [ADDR_W-1:0] rd_cnt_reg;
  logic              issue;

  logic [RD_LAT-1:0] tag_valid_reg;
  logic [RD_LAT-1:0] tag_valid_next;
  logic [RD_LAT-1:0] tag_last_reg;
  logic [RD_LAT-1:0] tag_last_next;
  logic [CNT_W-1:0]  inflight;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [OUT_W:0]    fifo_head;
  logic [OUT_W:0]    fifo_in;
  logic              head_last;
  logic [CNT_W:0]    credit_use;
  logic              credit_ok;

  logic signed [IN_W:0] acc_ext;
  logic signed [IN_W:0] rq_t;
  logic signed [IN_W:0] rq_r;
  logic [OUT_W-1:0]     rq_pix;

  // Both edge-detect flops reset high so a level already present at reset release cannot start a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q_reg  <= 1'b1;
      done_q2_reg <= 1'b1;
    end else begin
      done_q_reg  <= strip_done;
      done_q2_reg <= done_q_reg;
    end
  end

  assign start_rise = done_q_reg && !done_q2_reg;

  // Tag pipeline mirrors the BRAM read latency so data is captured exactly when it lands.
  genvar gi;
  assign tag_valid_next[0] = issue;
  assign tag_last_next[0]  = issue && (rd_cnt_reg == LAST_ADDR);
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_tag
      assign tag_valid_next[gi] = tag_valid_reg[gi-1];
      assign tag_last_next[gi]  = tag_last_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid_reg <= '0;
      tag_last_reg  <= '0;
    end else begin
      tag_valid_reg <= tag_valid_next;
      tag_last_reg  <= tag_last_next;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(tag_valid_reg[i]);
    end
  end

  // Round half up, arithmetic shift, then saturate into the output range.
  always_comb begin
    acc_ext = {strip_data[IN_W-1], strip_data};
    rq_t    = acc_ext + ROUND;
    rq_r    = rq_t >>> SHIFT;
    if (rq_r > SAT_HI) begin
      rq_pix = SAT_HI[OUT_W-1:0];
    end else if (rq_r < SAT_LO) begin
      rq_pix = SAT_LO[OUT_W-1:0];
    end else begin
      rq_pix = rq_r[OUT_W-1:0];
    end
  end

  assign fifo_push = tag_valid_reg[RD_LAT-1];
  assign fifo_in   = {tag_last_reg[RD_LAT-1], rq_pix};
  assign fifo_pop  = !fifo_empty && pix_ready;
  assign head_last = fifo_head[OUT_W];

  readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // A beat leaving this cycle frees its slot, which keeps one read per cycle when ready stays high.
  assign credit_use = {1'b0, fifo_count} + {1'b0, inflight} - (CNT_W + 1)'(fifo_pop);
  assign credit_ok  = credit_use < (CNT_W + 1)'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Address 0 is already on strip_addr while idle, so the first read issues with the start.
        if (start_rise) begin
          issue      = 1'b1;
          state_next = (LAST_ADDR == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rd_cnt_reg == LAST_ADDR) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && head_last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_reg <= '0;
    end else if (state_reg == DONE) begin
      rd_cnt_reg <= '0;
    end else if (issue && (rd_cnt_reg != LAST_ADDR)) begin
      rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end
  end

  assign strip_addr = rd_cnt_reg;
  assign pix_valid  = !fifo_empty;
  assign pix_data   = fifo_empty ? '0 : fifo_head[OUT_W-1:0];
  assign pix_last   = !fifo_empty && head_last;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_strip_result_readout.sv
// Scoreboard bench for strip_result_readout: 8-result strip, SHIFT=4, RD_LAT=2.
// Expected pixels are queued when a drain is started and popped on each accepted beat.
module tb_strip_result_readout;

  localparam int TB_COUNT  = 8;
  localparam int TB_RD_LAT = 2;
  localparam int NO_PULSE  = 100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        strip_done;
  logic [12:0] strip_addr;
  logic [22:0] strip_data;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        busy;
  logic        frame_done;

  logic signed [22:0] bram [TB_COUNT];
  logic [22:0] rd1;
  logic [22:0] rd2;
  logic [8:0]  exp_tab [TB_COUNT];
  logic [8:0]  sb [$];

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int acc_cnt = 0;
  int cyc_cnt = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  bit fd_due = 1'b0;
  bit prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  strip_result_readout #(
    .OUT_COUNT (TB_COUNT),
    .ADDR_W    (13),
    .IN_W      (23),
    .OUT_W     (8),
    .SHIFT     (4),
    .RD_LAT    (TB_RD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .strip_done (strip_done),
    .strip_addr (strip_addr),
    .strip_data (strip_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Two-cycle BRAM read model matching RD_LAT=2.
  always @(posedge clk) begin
    rd1 <= bram[strip_addr[2:0]];
    rd2 <= rd1;
  end
  assign strip_data = rd2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input int v);
    int r;
    r = (v + 8) >>> 4;
`ifdef STRIP_READOUT_RELU_EN
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
`else
    if (r < -128) r = -128;
    else if (r > 127) r = 127;
`endif
    return r[7:0];
  endfunction

  task automatic fill_exp_from_model();
    for (int a = 0; a < TB_COUNT; a++) begin
      exp_tab[a] = {(a == TB_COUNT - 1), model_pix(int'(bram[a]))};
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic [8:0] exp_w;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (reset) begin
        prev_stall = 1'b0;
        fd_due     = 1'b0;
      end else begin
        if (fd_due || frame_done) begin
          check("frame_done", frame_done, fd_due);
          if (frame_done) check("busy_in_done", busy, 1);
        end
        if (frame_done) fd_cnt++;
        fd_due = 1'b0;
        if (prev_stall) begin
          check("stall_valid", pix_valid, 1);
          check("stall_word", {pix_last, pix_data}, prev_word);
        end
        if (busy) check("addr_ahead", strip_addr <= acc_cnt + TB_RD_LAT + 1, 1);
        if (pix_valid && pix_ready) begin
          if (sb.size() == 0) begin
            check("extra_pixel", pix_valid, 0);
          end else begin
            exp_w = sb.pop_front();
            check("pix_data", pix_data, exp_w[7:0]);
            check("pix_last", pix_last, exp_w[8]);
          end
          if (acc_cnt == 0) first_acc_cyc = cyc_cnt;
          last_acc_cyc = cyc_cnt;
          acc_cnt++;
          if (pix_last) fd_due = 1'b1;
          $display("beat %0d: data=%0h last=%0b", acc_cnt, pix_data, pix_last);
        end
        prev_stall = pix_valid && !pix_ready;
        prev_word  = {pix_last, pix_data};
      end
    end
  end

  // Caller enters just after a rising edge with strip_done low.
  task automatic run_drain(input bit rnd, input int pulse_at, input bit chk_lat);
    int fd0;
    int lat;
    fd0 = fd_cnt;
    acc_cnt = 0;
    for (int a = 0; a < TB_COUNT; a++) sb.push_back(exp_tab[a]);
    pix_ready  = 1'b1;
    strip_done = 1'b1;
    if (chk_lat) begin
      @(posedge clk);
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (!pix_valid && lat < 20);
      check("first_valid_lat", lat, TB_RD_LAT + 1);
    end
    for (int c = 0; c < 600 && fd_cnt == fd0; c++) begin
      @(posedge clk);
      #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == pulse_at) strip_done = 1'b0;
      if (c == pulse_at + 1) begin
        strip_done = 1'b1;
        check("busy_at_retrig", busy, 1);
      end
    end
    check("frame_count", fd_cnt - fd0, 1);
    check("sb_drained", sb.size(), 0);
    $display("drain: %0d beats accepted, frames=%0d", acc_cnt, fd_cnt);
    pix_ready = 1'b1;
  endtask

  task automatic quiet_check(input string tag);
    int fd0;
    fd0 = fd_cnt;
    repeat (20) @(posedge clk);
    #1;
    check(tag, fd_cnt, fd0);
    check("idle_busy", busy, 0);
    check("idle_addr", strip_addr, 0);
  endtask

  task automatic lower_start();
    strip_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int fd0;
    int guard;
    reset      = 1'b1;
    strip_done = 1'b0;
    pix_ready  = 1'b1;
    for (int a = 0; a < TB_COUNT; a++) bram[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", strip_addr, 0);
    check("rst_data", pix_data, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Free flow: addr*16+8 requantises to addr+1.
    for (int a = 0; a < TB_COUNT; a++) bram[a] = 23'(a * 16 + 8);
    fill_exp_from_model();
    for (int a = 0; a < TB_COUNT; a++) exp_tab[a] = {(a == TB_COUNT - 1), 8'(a + 1)};
    run_drain(1'b0, NO_PULSE, 1'b1);
    check("burst_len", last_acc_cyc - first_acc_cyc, TB_COUNT - 1);
    quiet_check("held_level_no_retrig");

    // Rounding and clamp, second drain via a fresh rise.
    lower_start();
    bram[0] = 23'sd7;
    bram[1] = 23'sd8;
    bram[2] = 23'sd5000;
    bram[3] = -23'sd40;
    bram[4] = -23'sd5000;
    bram[5] = 23'sd2039;
    bram[6] = 23'sd2040;
    bram[7] = -23'sd2056;
    fill_exp_from_model();
`ifdef STRIP_READOUT_RELU_EN
    exp_tab[0] = 9'h000; exp_tab[1] = 9'h001; exp_tab[2] = 9'h0FF; exp_tab[3] = 9'h000;
`else
    exp_tab[0] = 9'h000; exp_tab[1] = 9'h001; exp_tab[2] = 9'h07F; exp_tab[3] = 9'h0FE;
`endif
    run_drain(1'b0, NO_PULSE, 1'b0);

    // Backpressure with random values and random ready.
    for (int k = 0; k < 3; k++) begin
      lower_start();
      for (int a = 0; a < TB_COUNT; a++) bram[a] = 23'($signed($urandom_range(0, 12000)) - 6000);
      fill_exp_from_model();
      run_drain(1'b1, NO_PULSE, 1'b0);
    end

    // Re-trigger while busy is ignored.
    lower_start();
    fill_exp_from_model();
    run_drain(1'b1, 3, 1'b0);
    quiet_check("retrig_no_extra");

    // Reset mid-drain after 3 accepted beats.
    lower_start();
    for (int a = 0; a < TB_COUNT; a++) bram[a] = 23'(a * 16 + 8);
    fill_exp_from_model();
    acc_cnt = 0;
    for (int a = 0; a < TB_COUNT; a++) sb.push_back(exp_tab[a]);
    strip_done = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (acc_cnt < 3 && guard < 100);
    check("abort_reached_3", acc_cnt, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", strip_addr, 0);
    check("abort_last", pix_last, 0);
    check("abort_done", frame_done, 0);
    sb.delete();
    fd0 = fd_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_frame", fd_cnt, fd0);
    check("abort_held_level", busy, 0);
    lower_start();
    run_drain(1'b0, NO_PULSE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
